rca_seq_ctrl: RTL

RCA_SEQ_CTRL -- requirements
Module: rca_seq_ctrl

---
 rtl/rca_pkg.sv | 16 +
 rtl/rca.sv | 29 ++
 rtl/rca_seq_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared constants and FSM state type for the sequential ripple-carry adder
package rca_pkg;

    // Width of one datapath slice handled by the shared adder per cycle.
    localparam int SLICE_W = 3;

    // Width of the completed-operation counter.
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/rca.sv
// rtl/rca.sv - 3-bit combinational ripple-carry adder used as the shared slice datapath
//
// Ports:
//   a, b  : slice operands
//   cin   : carry into bit 0
//   sum   : slice sum
//   cout  : carry out of the top bit
module rca
    import rca_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign sum[i]    = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1]  = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[SLICE_W];

endmodule

// File: rtl/rca_seq_ctrl.sv
// rtl/rca_seq_ctrl.sv - multi-cycle adder that reuses one 3-bit ripple adder across operand slices
//
// Ports:
//   clk, rst_n          : clock and synchronous active-low reset
//   in_valid / in_ready : operand handshake; a, b, cin captured when both high
//   a, b, cin           : operands and carry-in
//   out_valid/out_ready : result handshake
//   sum, cout           : registered result and final carry
//   busy                : FSM is not idle
//   op_count            : number of completed result handshakes (wraps)
module rca_seq_ctrl
    import rca_pkg::*;
#(
    parameter  int NUM_SLICES = 4,
    localparam int OP_W       = SLICE_W * NUM_SLICES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OP_W-1:0]  sum,
    output logic             cout,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

    state_t               r_state;
    state_t               w_next_state;

    logic [OP_W-1:0]      r_a;
    logic [OP_W-1:0]      r_b;
    logic [OP_W-1:0]      r_sum;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_carry;
    logic                 r_cout;
    logic [CNT_W-1:0]     r_op_count;

    logic [SLICE_W-1:0]   w_a_slice;
    logic [SLICE_W-1:0]   w_b_slice;
    logic [SLICE_W-1:0]   w_add_sum;
    logic                 w_add_cout;
    logic                 w_last;

    // Select the operand slice addressed by the current index.
    always_comb begin
        w_a_slice = '0;
        w_b_slice = '0;
        for (int i = 0; i < NUM_SLICES; i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_a_slice = r_a[i*SLICE_W +: SLICE_W];
                w_b_slice = r_b[i*SLICE_W +: SLICE_W];
            end
        end
    end

    assign w_last = (r_idx == IDX_W'(NUM_SLICES - 1));

    rca u_rca (
        .a    (w_a_slice),
        .b    (w_b_slice),
        .cin  (r_carry),
        .sum  (w_add_sum),
        .cout (w_add_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_next_state = RUN;
            RUN:     if (w_last)    w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default:                w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_sum      <= '0;
            r_idx      <= '0;
            r_carry    <= 1'b0;
            r_cout     <= 1'b0;
            r_op_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NUM_SLICES; i++) begin
                        if (r_idx == IDX_W'(i)) begin
                            r_sum[i*SLICE_W +: SLICE_W] <= w_add_sum;
                        end
                    end
                    r_carry <= w_add_cout;
                    r_idx   <= r_idx + 1'b1;
                    if (w_last) begin
                        r_cout <= w_add_cout;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_op_count <= r_op_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Ready is masked by reset so no handshake can be claimed while the block is held.
    assign in_ready  = rst_n && (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign op_count  = r_op_count;

endmodule
